// File: rtl/mem_edit_pkg.sv
// Shared types and constants for the keypad-driven RAM editor.
package mem_edit_pkg;

    localparam int unsigned NUM_KEYS = 4;

    localparam int unsigned K_AINC = 3;
    localparam int unsigned K_ADEC = 2;
    localparam int unsigned K_DINC = 1;
    localparam int unsigned K_DDEC = 0;

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        WRITE,
        SETTLE
    } state_e;

    typedef enum logic [2:0] {
        CMD_NONE,
        CMD_AINC,
        CMD_ADEC,
        CMD_DINC,
        CMD_DDEC
    } cmd_e;

endpackage

// File: rtl/mem_edit_ctrl_key_conditioner.sv
// One pushbutton: debounce, press-edge detect and auto-repeat, producing a one-cycle event.
module key_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 50_000,
    parameter int unsigned REPEAT_DELAY    = 25_000_000,
    parameter int unsigned REPEAT_RATE     = 5_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic ev
);

    localparam int unsigned MAX_DR = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned MAX_P  = (DEBOUNCE_CYCLES > MAX_DR) ? DEBOUNCE_CYCLES : MAX_DR;
    localparam int unsigned CW     = $clog2(MAX_P) + 1;

    logic          level;
    logic [CW-1:0] db_cnt;
    logic [CW-1:0] rep_cnt;
    logic          rep_first;

    // The repeat branch may override the debounce branch's ev on the release edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            level     <= 1'b1;
            db_cnt    <= '0;
            rep_cnt   <= '0;
            rep_first <= 1'b1;
            ev        <= 1'b0;
        end else begin
            ev <= 1'b0;

            if (key_n == level) begin
                db_cnt <= '0;
            end else if (db_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                db_cnt <= '0;
                level  <= key_n;
                ev     <= ~key_n;
            end else begin
                db_cnt <= db_cnt + CW'(1);
            end

            if (level) begin
                rep_cnt   <= '0;
                rep_first <= 1'b1;
            end else if (rep_cnt == (rep_first ? CW'(REPEAT_DELAY - 1) : CW'(REPEAT_RATE - 1))) begin
                rep_cnt   <= '0;
                rep_first <= 1'b0;
                ev        <= 1'b1;
            end else begin
                rep_cnt <= rep_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/mem_edit_ctrl.sv
// Keypad front end plus read-modify-write sequencer for a single-port RAM with 1-cycle read latency.
module mem_edit_ctrl
    import mem_edit_pkg::*;
#(
    parameter int unsigned AW              = 4,
    parameter int unsigned DW              = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 50_000,
    parameter int unsigned REPEAT_DELAY    = 25_000_000,
    parameter int unsigned REPEAT_RATE     = 5_000_000,
    parameter int unsigned SATURATE        = 0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [3:0]    KEY,
    input  logic [DW-1:0] dout,
    output logic [AW-1:0] a,
    output logic [DW-1:0] din,
    output logic          we,
    output logic          busy
);

    logic [NUM_KEYS-1:0] key_ev;
    cmd_e                cmd_c;
    state_e              state;
    logic                dir_inc;

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        key_conditioner #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_RATE    (REPEAT_RATE)
        ) u_key (
            .clk  (clk),
            .reset(reset),
            .key_n(KEY[k]),
            .ev   (key_ev[k])
        );
    end

    // Fixed-priority pick; losers are simply dropped.
    always_comb begin
        cmd_c = CMD_NONE;
        if (key_ev[K_AINC])      cmd_c = CMD_AINC;
        else if (key_ev[K_ADEC]) cmd_c = CMD_ADEC;
        else if (key_ev[K_DINC]) cmd_c = CMD_DINC;
        else if (key_ev[K_DDEC]) cmd_c = CMD_DDEC;
    end

    function automatic logic [DW-1:0] step(input logic [DW-1:0] v, input logic inc);
        if (SATURATE != 0) begin
            if (inc && (v == {DW{1'b1}})) return v;
            if (!inc && (v == '0))        return v;
        end
        return inc ? (v + DW'(1)) : (v - DW'(1));
    endfunction

    // Commands are only taken in IDLE, so busy also gates the arbiter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            a       <= '0;
            din     <= '0;
            we      <= 1'b0;
            busy    <= 1'b0;
            dir_inc <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    case (cmd_c)
                        CMD_AINC: a <= a + AW'(1);
                        CMD_ADEC: a <= a - AW'(1);
                        CMD_DINC, CMD_DDEC: begin
                            dir_inc <= (cmd_c == CMD_DINC);
                            busy    <= 1'b1;
                            state   <= RD_WAIT;
                        end
                        default: ;
                    endcase
                end
                RD_WAIT: begin
                    din   <= step(dout, dir_inc);
                    we    <= 1'b1;
                    state <= WRITE;
                end
                WRITE: begin
                    we    <= 1'b0;
                    state <= SETTLE;
                end
                SETTLE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
